// File: rtl/rs_encoder_if.sv
// ---------------------------------------------------------------------------
// rs_encoder_if
// Purpose : groups the symbol-stream signals of the RS(31,27) encoder.
// Signals :
//   datain     [4:0]  message symbol from upstream (bit 4 = coeff of x^4)
//   in_valid          datain is valid this cycle
//   in_ready          encoder can take a symbol this cycle
//   dataout    [4:0]  codeword symbol to downstream
//   out_valid         dataout is valid this cycle (no backpressure)
//   out_sop           first codeword symbol
//   out_eop           last codeword symbol (parity p0)
//   state_dbg  [1:0]  encoder FSM state, for observation only
// Handshake: a symbol transfers on a rising clock edge where
// in_valid & in_ready are both high; in_valid while in_ready is low is
// ignored. The output side has no ready: out_valid marks every valid
// dataout and downstream must take it.
// Modports: master = upstream/downstream environment, slave = encoder.
// ---------------------------------------------------------------------------
interface rs_encoder_if;
   logic [4:0] datain;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] dataout;
   logic       out_valid;
   logic       out_sop;
   logic       out_eop;
   logic [1:0] state_dbg;

   modport master (
      output datain, in_valid,
      input  in_ready, dataout, out_valid, out_sop, out_eop, state_dbg
   );

   modport slave (
      input  datain, in_valid,
      output in_ready, dataout, out_valid, out_sop, out_eop, state_dbg
   );
endinterface

// File: rtl/rs_encoder.sv
// ---------------------------------------------------------------------------
// rs_encoder
// Purpose : systematic RS(31,27) encoder over GF(2^5), p(x)=x^5+x^2+1.
//           Passes the 27 message symbols through (one cycle registered),
//           then emits the 4 parity symbols p3..p0 of x^4*m(x) mod g(x).
// Ports   :
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    rs_encoder_if.slave (symbol input, codeword output, debug state)
// ---------------------------------------------------------------------------
module rs_encoder (
   input  logic        clock,
   input  logic        reset,
   rs_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MSG    = 2'd1,
      PARITY = 2'd2
   } state_t;

   // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
   localparam logic [4:0] G3 = 5'h1E;
   localparam logic [4:0] G2 = 5'h06;
   localparam logic [4:0] G1 = 5'h09;
   localparam logic [4:0] G0 = 5'h11;

   // Polynomial-basis multiply; x^5 folds back to x^2 + 1.
   function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] acc;
      logic [4:0] aa;
      acc = '0;
      aa  = a;
      for (int i = 0; i < 5; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = aa[4] ? ({aa[3:0], 1'b0} ^ 5'h05) : {aa[3:0], 1'b0};
      end
      return acc;
   endfunction

   state_t          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [3:0][4:0] r_q, r_d;
   logic [4:0]      dout_q, dout_d;
   logic            oval_q, oval_d;
   logic            sop_q, sop_d;
   logic            eop_q, eop_d;

   logic            ready;
   logic            accept;
   logic [4:0]      fb;

   assign ready  = (state_q != PARITY);
   assign accept = bus.in_valid & ready;
   assign fb     = bus.datain ^ r_q[3];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      dout_d  = '0;
      oval_d  = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;

      case (state_q)
         IDLE, MSG: begin
            if (accept) begin
               r_d[3] = r_q[2] ^ gf_mul(fb, G3);
               r_d[2] = r_q[1] ^ gf_mul(fb, G2);
               r_d[1] = r_q[0] ^ gf_mul(fb, G1);
               r_d[0] = gf_mul(fb, G0);
               dout_d = bus.datain;
               oval_d = 1'b1;
               sop_d  = (cnt_q == 5'd0);
               if (cnt_q == 5'd26) begin
                  state_d = PARITY;
                  cnt_d   = 5'd27;
               end else begin
                  state_d = MSG;
                  cnt_d   = cnt_q + 5'd1;
               end
            end
         end
         PARITY: begin
            // Shift remainder out highest-first; zeros fill behind so the
            // LFSR is clear again when the block ends.
            dout_d = r_q[3];
            oval_d = 1'b1;
            eop_d  = (cnt_q == 5'd30);
            r_d[3] = r_q[2];
            r_d[2] = r_q[1];
            r_d[1] = r_q[0];
            r_d[0] = '0;
            if (cnt_q == 5'd30) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d   = cnt_q + 5'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            r_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         r_q     <= '0;
         dout_q  <= 5'd0;
         oval_q  <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         dout_q  <= dout_d;
         oval_q  <= oval_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.dataout   = dout_q;
   assign bus.out_valid = oval_q;
   assign bus.out_sop   = sop_q;
   assign bus.out_eop   = eop_q;
   assign bus.state_dbg = state_q;

endmodule
